// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the boot-time instruction loader.
//   - Default word / address widths (mirror the CPU's define.v values).
//   - Frame sync byte.
//   - FSM state encoding (3 bits).
package prog_loader_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int ISIZE_DEF = 16;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_CNT_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHK     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: writes a framed byte stream into instruction memory at boot
// and holds the CPU in reset until a checksum-valid image is in place.
//
// Frame: A5, CNT_HI, CNT_LO, N x (word hi, word lo), CHK
//        CHK = XOR of CNT_HI, CNT_LO and all payload bytes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   rx_valid   rx_data holds a byte
//   rx_data    incoming byte
//   rx_ready   loader can take a byte (low only when DONE)
//   start      one-cycle pulse, re-arms the loader from DONE or ERR
//   mem_wen    instruction-memory write enable, one-cycle pulse per word
//   mem_addr   write address (BASE_ADDR + word index, wraps)
//   mem_wdata  write data
//   cpu_hold   1 = CPU held in reset (straight from a flop)
//   done       image loaded and verified
//   error      load failed (oversize count or checksum mismatch)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ISIZE     = ISIZE_DEF,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  input  logic             start,
  output logic             mem_wen,
  output logic [ISIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam logic [16:0]      MAX_CNT  = 17'(MAX_WORDS);
  localparam logic [ISIZE-1:0] BASE_VAL = ISIZE'(BASE_ADDR);

  state_t state, state_nxt;

  logic [15:0]      cnt, cnt_nxt;
  logic [15:0]      idx, idx_nxt;
  logic [7:0]       hi, hi_nxt;
  logic [7:0]       acc, acc_nxt;
  logic             wen_nxt;
  logic [ISIZE-1:0] addr_nxt;
  logic [DSIZE-1:0] wdata_nxt;
  logic             hold_nxt, done_nxt, error_nxt;

  logic             accept;
  logic [15:0]      count_in;
  logic [15:0]      idx_inc;

  assign rx_ready = (state != ST_DONE);
  assign accept   = rx_valid & rx_ready;
  // Full count as it appears when the low byte is on rx_data.
  assign count_in = {cnt[15:8], rx_data};
  assign idx_inc  = idx + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    hi_nxt    = hi;
    acc_nxt   = acc;
    wen_nxt   = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    hold_nxt  = cpu_hold;
    done_nxt  = done;
    error_nxt = error;

    case (state)
      ST_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_nxt = ST_CNT_HI;
          acc_nxt   = 8'h00;
        end
      end

      ST_CNT_HI: begin
        if (accept) begin
          cnt_nxt[15:8] = rx_data;
          acc_nxt       = acc ^ rx_data;
          state_nxt     = ST_CNT_LO;
        end
      end

      ST_CNT_LO: begin
        if (accept) begin
          cnt_nxt = count_in;
          acc_nxt = acc ^ rx_data;
          if ({1'b0, count_in} > MAX_CNT) begin
            state_nxt = ST_ERR;
            error_nxt = 1'b1;
          end else if (count_in == 16'd0) begin
            state_nxt = ST_CHK;
          end else begin
            state_nxt = ST_DATA_HI;
            idx_nxt   = 16'd0;
          end
        end
      end

      ST_DATA_HI: begin
        if (accept) begin
          hi_nxt    = rx_data;
          acc_nxt   = acc ^ rx_data;
          state_nxt = ST_DATA_LO;
        end
      end

      ST_DATA_LO: begin
        if (accept) begin
          acc_nxt   = acc ^ rx_data;
          wen_nxt   = 1'b1;
          wdata_nxt = DSIZE'({hi, rx_data});
          addr_nxt  = BASE_VAL + ISIZE'(idx);
          idx_nxt   = idx_inc;
          state_nxt = (idx_inc == cnt) ? ST_CHK : ST_DATA_HI;
        end
      end

      ST_CHK: begin
        if (accept) begin
          if (rx_data == acc) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            hold_nxt  = 1'b0;
          end else begin
            state_nxt = ST_ERR;
            error_nxt = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b0;
          hold_nxt  = 1'b1;
        end
      end

      ST_ERR: begin
        // start takes priority over a simultaneous sync byte.
        if (start) begin
          state_nxt = ST_IDLE;
          error_nxt = 1'b0;
        end else if (accept && rx_data == SYNC_BYTE) begin
          state_nxt = ST_CNT_HI;
          error_nxt = 1'b0;
          acc_nxt   = 8'h00;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      idx       <= '0;
      hi        <= '0;
      acc       <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= BASE_VAL;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      hi        <= hi_nxt;
      acc       <= acc_nxt;
      mem_wen   <= wen_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      cpu_hold  <= hold_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the instruction memory that the pipelined CPU otherwise only reads.
- Accepts a framed byte stream (sync, word count, big-endian 16-bit words, checksum) and writes each word into instruction memory through its write port.
- Holds the CPU in reset until a complete, checksum-valid image has been loaded.
- Sits between a byte source (UART receiver or testbench) and the instruction memory wen/addr/data_in port.

Parameters:
- DSIZE, 16, instruction/data word width (matches define.v).
- ISIZE, 16, instruction address width (matches define.v).
- BASE_ADDR, 0, instruction-memory address of the first loaded word.
- MAX_WORDS, 4096, largest accepted word count; any larger count is an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader can take a byte; a byte transfers on rx_valid & rx_ready at a rising edge.
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR.
- mem_wen  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  ISIZE  write address.
- mem_wdata  out  DSIZE  write data.
- cpu_hold  out  1  1 = CPU held in reset.
- done  out  1  image loaded and verified.
- error  out  1  load failed (bad count or bad checksum).

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; cpu_hold = 1; done = 0; error = 0; mem_wen = 0; mem_addr = BASE_ADDR; mem_wdata = 0.
  - Word index and checksum accumulator are cleared.
- Registered outputs: every output except rx_ready. rx_ready is decoded from state.
  - rx_ready = 1 in every state except DONE.
- Frame format: 0xA5, CNT_HI, CNT_LO, then N words sent as hi byte then lo byte, then CHK.
  - CHK = XOR of CNT_HI, CNT_LO and every payload byte. The sync byte is not included.
- States and transitions (each transition happens on an accepted byte unless noted):
  - IDLE: a byte equal to 0xA5 goes to CNT_HI and clears the accumulator. Any other byte is discarded; state stays IDLE.
  - CNT_HI: latch the byte and XOR it into the accumulator; go to CNT_LO.
  - CNT_LO: latch the byte and XOR it in.
    - count > MAX_WORDS: go to ERR.
    - count = 0: go to CHK.
    - otherwise: go to DATA_HI with word index = 0.
  - DATA_HI: latch the byte as the upper half of the word, XOR it in; go to DATA_LO.
  - DATA_LO: XOR the byte in.
    - On the next edge: mem_wen = 1, mem_wdata = {hi, lo}, mem_addr = BASE_ADDR + index (mod 2^ISIZE, wraps silently).
    - Increment index. Go to CHK if index+1 = count, else DATA_HI.
  - CHK:
    - Byte equals the accumulator: go to DONE; done = 1, cpu_hold = 0.
    - Otherwise: go to ERR; error = 1.
  - DONE: all bytes are ignored (rx_ready = 0). A start pulse goes to IDLE; done = 0, cpu_hold = 1.
  - ERR: cpu_hold stays 1 and error stays 1.
    - A start pulse goes to IDLE and clears error.
    - An accepted 0xA5 goes directly to CNT_HI, clears error and clears the accumulator.
    - Other bytes are discarded.
- start pulses arriving in any other state are ignored.
- mem_wen timing: high for exactly one cycle, the cycle after the DATA_LO byte is accepted. Back-to-back bytes give at most one write per two cycles.
- Between writes, mem_addr and mem_wdata keep their last values.
- On error, memory contents already written are undefined for use. The CPU stays held.
- rx_valid gaps: any number of idle cycles between bytes are allowed; state is held.
- Reset asserted mid-frame: immediate return to IDLE and the reset values above. A pending write is dropped.
- cpu_hold is driven straight from a flop (glitch-free) and is intended to be ANDed into the CPU's rst.

Decomposition:
- Shared package or define file:
  - State encoding (IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, DONE, ERR; 3 bits).
  - SYNC_BYTE = 8'hA5.
  - DSIZE and ISIZE come from define.v.
- No sub-module is needed: one FSM plus a datapath of word index, count register, hi-byte register and XOR accumulator.

Test Plan:
- Reset: rst=0 → cpu_hold=1, done=0, error=0, mem_wen=0, mem_addr=0, rx_ready=1 after release.
- Good load: stream A5 00 02 12 34 AB CD 42 back-to-back → mem writes 0x1234@0x0000 and 0xABCD@0x0001, each a one-cycle mem_wen. Then done=1, cpu_hold=0, rx_ready=0.
- Bad checksum: same stream with 43 as CHK → both writes occur, then error=1, done=0, cpu_hold=1. A following A5 00 00 00 → error clears, done=1.
- Noise and empty image: bytes 00 FF 5A, then A5 00 00 00 with random rx_valid gaps → noise ignored, no mem_wen, done=1.
- Oversize count: A5 10 01 (4097 words) → ERR right after CNT_LO with no writes. start pulse → IDLE, error=0.
- Mid-frame reset: A5 00 03 11 22 33, then rst=0 for 2 cycles → mem_wen stays 0 after reset assertion, state IDLE, cpu_hold=1. A subsequent full frame loads from address 0.
